// File: rtl/alu_acc_sequencer.sv
// Accumulator command sequencer driving the operand/select side of the 8-bit combinational ALU.
// Optional feature macro ALU_SEQ_REPEAT_EN: ALU ops iterate cmd_rep+1 times, chaining Result into A.

module alu_acc_sequencer #(
  parameter int unsigned ACC_W = 8,
  parameter int unsigned REP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [ACC_W-1:0] cmd_data,
  input  logic [REP_W-1:0] cmd_rep,
  output logic [ACC_W-1:0] alu_a,
  output logic [ACC_W-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [ACC_W-1:0] alu_result,
  input  logic             alu_zflag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [ACC_W-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_err
);

  localparam int unsigned OP_W  = 4;
  localparam int unsigned SEL_W = 3;

  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_READ  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_CLEAR = OP_W'(2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [ACC_W-1:0]   acc, acc_nxt;
  logic [ACC_W-1:0]   alu_a_nxt, alu_b_nxt;
  logic [SEL_W-1:0]   alu_sel_nxt;
  logic               cmd_ready_nxt;
  logic               rsp_valid_nxt, rsp_zero_nxt, rsp_err_nxt;
  logic [ACC_W-1:0]   rsp_data_nxt;

`ifdef ALU_SEQ_REPEAT_EN
  logic [REP_W-1:0]   rep_cnt, rep_cnt_nxt;
`else
  // Repeat count has no meaning in the single-iteration build.
  logic               unused_rep;
  assign unused_rep = ^cmd_rep;
`endif

  // Next-state and next-register values.
  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    alu_a_nxt     = alu_a;
    alu_b_nxt     = alu_b;
    alu_sel_nxt   = alu_sel;
    rsp_valid_nxt = rsp_valid;
    rsp_data_nxt  = rsp_data;
    rsp_zero_nxt  = rsp_zero;
    rsp_err_nxt   = rsp_err;
`ifdef ALU_SEQ_REPEAT_EN
    rep_cnt_nxt   = rep_cnt;
`endif

    case (state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_op[OP_W-1]) begin
            alu_a_nxt   = acc;
            alu_b_nxt   = cmd_data;
            alu_sel_nxt = cmd_op[SEL_W-1:0];
`ifdef ALU_SEQ_REPEAT_EN
            rep_cnt_nxt = cmd_rep;
`endif
            state_nxt   = ST_EXEC;
          end else begin
            rsp_err_nxt = 1'b0;
            case (cmd_op)
              OP_LOAD:  acc_nxt = cmd_data;
              OP_READ:  acc_nxt = acc;
              OP_CLEAR: acc_nxt = '0;
              default:  rsp_err_nxt = 1'b1;
            endcase
            rsp_valid_nxt = 1'b1;
            rsp_data_nxt  = acc_nxt;
            rsp_zero_nxt  = (acc_nxt == '0);
            state_nxt     = ST_RESP;
          end
        end
      end

      ST_EXEC: begin
`ifdef ALU_SEQ_REPEAT_EN
        if (rep_cnt != '0) begin
          // Chain the running result back into A; B and select stay put.
          alu_a_nxt   = alu_result;
          rep_cnt_nxt = rep_cnt - REP_W'(1);
        end else begin
          acc_nxt       = alu_result;
          rsp_valid_nxt = 1'b1;
          rsp_data_nxt  = alu_result;
          rsp_zero_nxt  = alu_zflag;
          rsp_err_nxt   = 1'b0;
          state_nxt     = ST_RESP;
        end
`else
        acc_nxt       = alu_result;
        rsp_valid_nxt = 1'b1;
        rsp_data_nxt  = alu_result;
        rsp_zero_nxt  = alu_zflag;
        rsp_err_nxt   = 1'b0;
        state_nxt     = ST_RESP;
`endif
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          rsp_err_nxt   = 1'b0;
          state_nxt     = ST_IDLE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    // Ready is a registered copy of "will be idle", so it drops on the accepting edge.
    cmd_ready_nxt = (state_nxt == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
`ifdef ALU_SEQ_REPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      alu_a     <= alu_a_nxt;
      alu_b     <= alu_b_nxt;
      alu_sel   <= alu_sel_nxt;
      cmd_ready <= cmd_ready_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_data  <= rsp_data_nxt;
      rsp_zero  <= rsp_zero_nxt;
      rsp_err   <= rsp_err_nxt;
`ifdef ALU_SEQ_REPEAT_EN
      rep_cnt   <= rep_cnt_nxt;
`endif
    end
  end

endmodule
